branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Fetch-side producer of the next-PC decision. It gives IF a predicted next PC for the current fetch PC and takes resolution updates from EX.
- It is a gshare predictor: a direct-mapped BTB, a PHT of 2-bit saturating counters, and a global branch history register (BHR).
- EX-stage mispredict redirect logic compares against the prediction and sends outcomes back through the update port.
- Also keeps prediction and mispredict statistics.

Parameters:
- BTB_IDX_BITS, 5, BTB/PHT index width. Entries = 2**BTB_IDX_BITS. Index taken from pc[BTB_IDX_BITS+1:2].
- BHR_BITS, 5, global history width. Must be <= BTB_IDX_BITS. XORed into the low PHT index bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low. Sampled on the rising clk edge; reset==0 clears all state.
- if_pc  in  32  PC currently in IF.
- stall  in  1  IF held this cycle; suppresses the speculative BHR shift.
- pred_taken  out  1  predicted taken for if_pc.
- pred_next_pc  out  32  predicted next PC.
- pred_bhr  out  BHR_BITS  BHR value used for this lookup; carried down the pipeline.
- pred_hit  out  1  BTB tag hit for if_pc; carried down the pipeline.
- upd_valid  in  1  EX resolves a control-flow instruction this cycle (branch/jal/jalr).
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  actual direction (jal/jalr always 1).
- upd_target  in  32  actual taken target.
- upd_bhr  in  BHR_BITS  pred_bhr snapshot travelling with the instruction.
- upd_hit  in  1  pred_hit snapshot travelling with the instruction.
- upd_mispredict  in  1  EX detected actual next PC != predicted next PC.
- pred_count  out  32  number of upd_valid events.
- mispred_count  out  32  number of upd_valid && upd_mispredict events.

Behaviour:
- Storage, per entry: btb_valid (1), btb_tag (32-BTB_IDX_BITS-2 bits, = pc[31:BTB_IDX_BITS+2]), btb_target (32), pht (2 bits).
- Lookup (combinational from if_pc and current state):
  - idx = if_pc[BTB_IDX_BITS+1:2].
  - pred_hit = btb_valid[idx] && tag match.
  - pidx = idx ^ zero-extended bhr.
  - pred_taken = pred_hit && pht[pidx][1].
  - pred_next_pc = pred_taken ? btb_target[idx] : if_pc+4, modulo 2^32 (0xFFFFFFFC+4 = 0).
  - pred_bhr = bhr.
- Reads see pre-edge contents. An update at edge N is visible to lookups from cycle N+1; there is no bypass.
- Update at edge when upd_valid:
  - uidx = upd_pc index. upidx = uidx ^ upd_bhr.
  - PHT: upd_taken ? min(pht+1, 3) : max(pht-1, 0), at upidx.
  - BTB: if upd_taken, write btb_valid=1, tag, and target=upd_target at uidx, overwriting any occupant. Not-taken resolutions leave the BTB unchanged.
  - pred_count += 1. If upd_mispredict, mispred_count += 1. Both wrap at 2^32.
- BHR, in priority order:
  1. reset==0: BHR = 0.
  2. upd_valid && upd_mispredict (recovery): bhr <= upd_hit ? {upd_bhr[BHR_BITS-2:0], upd_taken} : upd_bhr.
  3. !stall && pred_hit (speculative): bhr <= {bhr[BHR_BITS-2:0], pred_taken}.
  4. Otherwise BHR holds.
- Simultaneous recovery and speculative shift: recovery wins; the wrong-path fetch shift is dropped.
- Update is independent of stall. A simultaneous update and lookup of the same index is legal and returns old data.
- Reset (reset==0 at an edge), from any state including mid-stream:
  - all btb_valid=0; all pht=2'b01 (weakly not-taken); bhr=0; both counters=0. Tag/target contents need not be cleared.
  - Update inputs are ignored that cycle.
- Outputs after reset: pred_taken=0, pred_hit=0, pred_next_pc=if_pc+4, pred_bhr=0, counts=0.

Test Plan:
1. Reset low 1 cycle, then if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_next_pc=0x104, pred_bhr=0, counts=0.
2. upd_valid=1, upd_pc=0x100, upd_taken=1, upd_target=0x200, upd_bhr=0, upd_hit=0, upd_mispredict=1 -> next cycle:
   - pht[0]=2, BHR=0, mispred_count=1, pred_count=1.
   - if_pc=0x100 gives pred_hit=1, pred_taken=1, pred_next_pc=0x200.
   - the following cycle (stall=0) BHR=5'b00001.
3. Counter saturation: three taken updates at pidx 0 -> pht=3. One not-taken -> pht=2, still predicts taken. Two more not-taken -> pht=0; a further not-taken stays 0.
4. Alias: after scenario 2, if_pc=0x180 (same index, different tag) -> pred_hit=0, pred_next_pc=0x184, BHR unchanged.
5. Priority and stall:
   - hit lookup with stall=1 -> BHR unchanged.
   - hit lookup with stall=0 in the same cycle as a mispredict update with upd_bhr=5'b10101, upd_hit=1, upd_taken=0 -> BHR=5'b01010.
6. Wrap and reset mid-run:
   - if_pc=0xFFFFFFFC with no hit -> pred_next_pc=0.
   - Populate several BTB entries, then reset low during an upd_valid cycle -> all lookups miss, pht=1, counts=0, and the update is not applied.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/resolve port bundle for the gshare branch predictor.
// IF-side lookup, EX-side update and statistics outputs.
interface branch_predictor_if #(
  parameter int BHR_BITS = 5
);
  logic [31:0]         if_pc;
  logic                stall;
  logic                pred_taken;
  logic [31:0]         pred_next_pc;
  logic [BHR_BITS-1:0] pred_bhr;
  logic                pred_hit;
  logic                upd_valid;
  logic [31:0]         upd_pc;
  logic                upd_taken;
  logic [31:0]         upd_target;
  logic [BHR_BITS-1:0] upd_bhr;
  logic                upd_hit;
  logic                upd_mispredict;
  logic [31:0]         pred_count;
  logic [31:0]         mispred_count;

  modport master (
    output if_pc, stall, upd_valid, upd_pc, upd_taken, upd_target,
           upd_bhr, upd_hit, upd_mispredict,
    input  pred_taken, pred_next_pc, pred_bhr, pred_hit,
           pred_count, mispred_count
  );

  modport slave (
    input  if_pc, stall, upd_valid, upd_pc, upd_taken, upd_target,
           upd_bhr, upd_hit, upd_mispredict,
    output pred_taken, pred_next_pc, pred_bhr, pred_hit,
           pred_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Gshare next-PC predictor: direct-mapped BTB, 2-bit PHT indexed by pc^BHR,
// speculative global history with EX-driven recovery, and resolve statistics.
module branch_predictor #(
  parameter int BTB_IDX_BITS = 5,
  parameter int BHR_BITS     = 5
) (
  input  logic              clk,
  input  logic              reset,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES  = 2**BTB_IDX_BITS;
  localparam int TAG_BITS = 32 - BTB_IDX_BITS - 2;

  logic                r_btb_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_btb_tag    [ENTRIES];
  logic [31:0]         r_btb_target [ENTRIES];
  logic [1:0]          r_pht        [ENTRIES];
  logic [BHR_BITS-1:0] r_bhr;
  logic [31:0]         r_pred_count;
  logic [31:0]         r_mispred_count;

  logic [BTB_IDX_BITS-1:0] w_idx;
  logic [BTB_IDX_BITS-1:0] w_pidx;
  logic [TAG_BITS-1:0]     w_tag;
  logic                    w_hit;
  logic                    w_taken;
  logic [BTB_IDX_BITS-1:0] w_uidx;
  logic [BTB_IDX_BITS-1:0] w_upidx;
  logic [TAG_BITS-1:0]     w_utag;
  logic [1:0]              w_upht;
  logic [1:0]              w_upht_next;
  logic                    w_unused;

  // Lookup path: purely combinational on pre-edge state, no update bypass.
  assign w_idx   = bp.if_pc[BTB_IDX_BITS+1:2];
  assign w_tag   = bp.if_pc[31:BTB_IDX_BITS+2];
  assign w_pidx  = w_idx ^ BTB_IDX_BITS'(r_bhr);
  assign w_hit   = r_btb_valid[w_idx] && (r_btb_tag[w_idx] == w_tag);
  assign w_taken = w_hit && r_pht[w_pidx][1];

  assign bp.pred_hit      = w_hit;
  assign bp.pred_taken    = w_taken;
  assign bp.pred_next_pc  = w_taken ? r_btb_target[w_idx] : bp.if_pc + 32'd4;
  assign bp.pred_bhr      = r_bhr;
  assign bp.pred_count    = r_pred_count;
  assign bp.mispred_count = r_mispred_count;

  assign w_uidx  = bp.upd_pc[BTB_IDX_BITS+1:2];
  assign w_utag  = bp.upd_pc[31:BTB_IDX_BITS+2];
  assign w_upidx = w_uidx ^ BTB_IDX_BITS'(bp.upd_bhr);
  assign w_upht  = r_pht[w_upidx];

  always_comb begin
    w_upht_next = w_upht;
    if (bp.upd_taken) begin
      if (w_upht != 2'b11) w_upht_next = w_upht + 2'b01;
    end else begin
      if (w_upht != 2'b00) w_upht_next = w_upht - 2'b01;
    end
  end

  assign w_unused = ^{bp.if_pc[1:0], bp.upd_pc[1:0]};

  // Per-entry state that must be cleared on reset.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_pht[gi]       <= 2'b01;
          r_btb_valid[gi] <= 1'b0;
        end else if (bp.upd_valid) begin
          if (w_upidx == BTB_IDX_BITS'(gi))
            r_pht[gi] <= w_upht_next;
          if (bp.upd_taken && (w_uidx == BTB_IDX_BITS'(gi)))
            r_btb_valid[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset && bp.upd_valid && bp.upd_taken) begin
      r_btb_tag[w_uidx]    <= w_utag;
      r_btb_target[w_uidx] <= bp.upd_target;
    end
  end

  // Recovery from a mispredict outranks the wrong-path speculative shift.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bhr           <= '0;
      r_pred_count    <= '0;
      r_mispred_count <= '0;
    end else begin
      if (bp.upd_valid && bp.upd_mispredict)
        r_bhr <= bp.upd_hit ? {bp.upd_bhr[BHR_BITS-2:0], bp.upd_taken} : bp.upd_bhr;
      else if (!bp.stall && w_hit)
        r_bhr <= {r_bhr[BHR_BITS-2:0], w_taken};
      if (bp.upd_valid) begin
        r_pred_count <= r_pred_count + 32'd1;
        if (bp.upd_mispredict)
          r_mispred_count <= r_mispred_count + 32'd1;
      end
    end
  end
endmodule
